cdb_result_queue: RTL and testbench
===================================

Name: cdb_result_queue

Overview:
- Per-functional-unit result buffer that sits directly upstream of the common data bus arbiter.
- Accepts completed results (tag, data) from one functional unit (adder, multiplier or load unit) and queues them in order.
- Presents the head entry to the CDB as request/tag/data and pops it on grant.
- Decouples unit completion from CDB arbitration loss, so a unit that loses arbitration is not forced to stall its pipeline.

Parameters:
- TAG_WIDTH, 4, width of reservation-station tag.
- DATA_WIDTH, 32, result data width.
- DEPTH, 4, number of queue entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- fu_valid  in  1  functional unit presents a completed result.
- fu_tag  in  TAG_WIDTH  tag of the completing result.
- fu_data  in  DATA_WIDTH  result value.
- fu_ready  out  1  queue can accept a result this cycle.
- flush  in  1  synchronous discard of all queued entries.
- cdb_request  out  1  head entry valid, requesting the CDB.
- cdb_tag  out  TAG_WIDTH  head entry tag.
- cdb_data  out  DATA_WIDTH  head entry data.
- cdb_grant  in  1  arbiter grants the CDB to this queue this cycle.
- count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow_err  out  1  sticky: a push was attempted while fu_ready = 0.

Behaviour:
- Storage: circular buffer of DEPTH entries. rd_ptr and wr_ptr are clog2(DEPTH) bits wide and wrap modulo DEPTH. The occupancy counter is registered.
- Reset (rst high, asynchronous): rd_ptr = 0, wr_ptr = 0, count = 0, overflow_err = 0. Entry contents are don't-care.
  - Outputs during and after reset: cdb_request = 0, fu_ready = 1, cdb_tag = 0, cdb_data = 0 while empty.
- fu_ready = (count < DEPTH). This is purely from registered state, with no combinational dependence on cdb_grant.
- push = fu_valid & fu_ready & ~flush. On push, the entry at wr_ptr is written and wr_ptr increments.
- cdb_request = (count != 0) & ~flush. It is driven from registered state only, so the arbiter's grant path has no loop.
- cdb_tag / cdb_data = head entry at rd_ptr when count != 0, else 0.
- pop = cdb_grant & cdb_request. On pop, rd_ptr increments.
  - A cdb_grant while cdb_request = 0 is ignored: no state change and no error.
- Latency: a result pushed in cycle N appears on cdb_request / cdb_tag / cdb_data in cycle N+1 at the earliest. No same-cycle bypass.
- Simultaneous push and pop (only possible when 0 < count < DEPTH): both pointers advance and count is unchanged.
  - When full, fu_ready = 0 even if a pop occurs that cycle. The push is refused, and fu_ready rises in the next cycle.
- Count update: +1 on push-only, -1 on pop-only, otherwise held. Count never exceeds DEPTH or goes below 0.
- Flush (synchronous, highest priority): next state is rd_ptr = wr_ptr = 0 and count = 0.
  - In the flush cycle, cdb_request is forced to 0, so no entry is broadcast, and any fu_valid is dropped.
  - overflow_err is unaffected by flush.
- overflow_err: set when fu_valid & ~fu_ready & ~flush. It is cleared only by rst.
- Order: strict FIFO. Tags are not inspected and duplicate tags are passed through unchanged.
- Reset asserted mid-operation: all entries are discarded immediately (asynchronously) and outputs return to their reset values.

Decomposition:
- Shared package (tomasulo_pkg): TAG_WIDTH default, DATA_WIDTH default, CDB source-ID constants (ADD, MUL, LOAD, NONE) and the CDB result-record field layout.
- One natural sub-module: cdb_queue_storage. It is a DEPTH x (TAG_WIDTH+DATA_WIDTH) register array with one write port and an asynchronous read port.
- Pointer, count, flush and error logic stay in cdb_result_queue.

Test Plan:
- Reset/idle: assert rst mid-stream with 2 entries queued -> cdb_request = 0, count = 0, fu_ready = 1, overflow_err = 0 immediately. First push after release is tag 3 -> next cycle cdb_tag = 3.
- Single result: push tag 5, data 0x0000_00AA in cycle N with grant held high -> cdb_request = 1, tag 5, data 0xAA in N+1; popped; count = 0 in N+2.
- Fill and backpressure: DEPTH = 4, grant low, push tags 1, 2, 3, 4 -> count = 4, fu_ready = 0. Then grant one cycle -> tag 1 popped, fu_ready = 1 next cycle, head tag = 2.
- Push/pop same cycle at count = 2 (head tag 7): push tag 9 with grant -> count stays 2, head becomes the entry behind 7. Drain order is preserved across pointer wrap after 10 continuous transactions.
- Flush: 3 entries queued, flush with simultaneous fu_valid (tag 6) and grant -> cdb_request = 0 that cycle, nothing popped to the CDB. Next cycle count = 0 and tag 6 is absent.
- Overflow: full queue, fu_valid = 1 with tag 8 -> overflow_err = 1 next cycle, tag 8 never appears on cdb_tag, and overflow_err stays 1 after a flush.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: default widths, CDB source IDs and the CDB result record.
package tomasulo_pkg;

  localparam int unsigned TAG_WIDTH_DEF  = 4;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    CDB_SRC_ADD  = 2'd0,
    CDB_SRC_MUL  = 2'd1,
    CDB_SRC_LOAD = 2'd2,
    CDB_SRC_NONE = 2'd3
  } cdb_src_e;

  // Result record as broadcast on the CDB (default widths).
  typedef struct packed {
    logic [TAG_WIDTH_DEF-1:0]  tag;
    logic [DATA_WIDTH_DEF-1:0] data;
  } cdb_result_t;

endpackage

// File: rtl/cdb_queue_storage.sv
// Entry array for the CDB result queue: one synchronous write port, one asynchronous read port.
module cdb_queue_storage #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 36
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cdb_result_queue.sv
// Per-unit FIFO of completed results feeding the CDB arbiter; pops the head on grant.
module cdb_result_queue
  import tomasulo_pkg::*;
#(
  parameter int unsigned TAG_WIDTH  = TAG_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fu_valid,
  input  logic [TAG_WIDTH-1:0]       fu_tag,
  input  logic [DATA_WIDTH-1:0]      fu_data,
  output logic                       fu_ready,
  input  logic                       flush,
  output logic                       cdb_request,
  output logic [TAG_WIDTH-1:0]       cdb_tag,
  output logic [DATA_WIDTH-1:0]      cdb_data,
  input  logic                       cdb_grant,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = TAG_WIDTH + DATA_WIDTH;

  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [ENTRY_W-1:0] head;
  logic               not_empty;
  logic               push;
  logic               pop;

  // Ready and request come only from registered occupancy, keeping the grant path loop-free.
  assign not_empty   = (count != '0);
  assign fu_ready    = (count < CNT_W'(DEPTH));
  assign cdb_request = not_empty & ~flush;
  assign push        = fu_valid & fu_ready & ~flush;
  assign pop         = cdb_grant & cdb_request;

  assign cdb_tag  = not_empty ? head[ENTRY_W-1 -: TAG_WIDTH] : '0;
  assign cdb_data = not_empty ? head[DATA_WIDTH-1:0]          : '0;

  cdb_queue_storage #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({fu_tag, fu_data}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointers and occupancy; flush wins over push/pop, overflow flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
      if (fu_valid && !fu_ready && !flush) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_result_queue.sv
// Randomized and directed scoreboard bench for cdb_result_queue against a queue-based model.
module tb_cdb_result_queue;

  localparam int unsigned TW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          fu_valid;
  logic [TW-1:0] fu_tag;
  logic [DW-1:0] fu_data;
  logic          fu_ready;
  logic          flush;
  logic          cdb_request;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic          cdb_grant;
  logic [CW-1:0] count;
  logic          overflow_err;

  int checks = 0;
  int errors = 0;

  logic [TW+DW-1:0] exp_q[$];   // entries the DUT should currently hold, head first
  logic [TW+DW-1:0] pend_q[$];  // accepted this cycle, visible from next cycle
  logic             ovf_exp = 1'b0;

  cdb_result_queue #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .fu_valid     (fu_valid),
    .fu_tag       (fu_tag),
    .fu_data      (fu_data),
    .fu_ready     (fu_ready),
    .flush        (flush),
    .cdb_request  (cdb_request),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_grant    (cdb_grant),
    .count        (count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; an accepted push is recorded for the monitor.
  task automatic step(input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d,
                      input logic g, input logic f);
    @(posedge clk);
    #1;
    fu_valid  = v;
    fu_tag    = t;
    fu_data   = d;
    cdb_grant = g;
    flush     = f;
    if (v && !f && !rst && exp_q.size() < DEPTH) pend_q.push_back({t, d});
  endtask

  // Monitor: compare outputs against the model mid-cycle, then apply this cycle's effects.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_request", 64'(cdb_request), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_ready", 64'(fu_ready), 64'(1));
        chk("rst_ovf", 64'(overflow_err), 64'(0));
        exp_q.delete();
        pend_q.delete();
        ovf_exp = 1'b0;
      end else begin
        chk("request", 64'(cdb_request), 64'((exp_q.size() != 0) && !flush));
        chk("count", 64'(count), 64'(exp_q.size()));
        chk("fu_ready", 64'(fu_ready), 64'(exp_q.size() < DEPTH));
        chk("overflow_err", 64'(overflow_err), 64'(ovf_exp));
        if (exp_q.size() != 0) begin
          chk("head_tag", 64'(cdb_tag), 64'(exp_q[0][TW+DW-1:DW]));
          chk("head_data", 64'(cdb_data), 64'(exp_q[0][DW-1:0]));
        end else begin
          chk("empty_tag", 64'(cdb_tag), 64'(0));
          chk("empty_data", 64'(cdb_data), 64'(0));
        end
        if (fu_valid && exp_q.size() == DEPTH && !flush) ovf_exp = 1'b1;
        if (flush) begin
          exp_q.delete();
        end else begin
          if (cdb_grant && exp_q.size() != 0) void'(exp_q.pop_front());
          while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
        end
        pend_q.delete();
      end
    end
  end

  initial begin
    rst = 1'b1; fu_valid = 1'b0; fu_tag = '0; fu_data = '0; cdb_grant = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single result with grant held
    step(1'b1, 4'd5, 32'h0000_00AA, 1'b1, 1'b0);
    step(1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    chk("single_count", 64'(count), 64'(0));

    // Fill to full, then one grant
    for (int i = 1; i <= 4; i++) step(1'b1, TW'(i), 32'(i * 16'h111), 1'b0, 1'b0);
    step(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    chk("fill_count", 64'(count), 64'(4));
    chk("fill_ready", 64'(fu_ready), 64'(0));
    step(1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    chk("after_pop_ready", 64'(fu_ready), 64'(1));
    chk("after_pop_tag", 64'(cdb_tag), 64'(2));
    repeat (4) step(1'b0, 4'd0, 32'h0, 1'b1, 1'b0);

    // Push and pop in the same cycle at count 2, then continuous traffic across wrap
    step(1'b1, 4'd7, 32'h7777, 1'b0, 1'b0);
    step(1'b1, 4'd11, 32'hBBBB, 1'b0, 1'b0);
    step(1'b1, 4'd9, 32'h9999, 1'b1, 1'b0);
    step(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    chk("pushpop_count", 64'(count), 64'(2));
    chk("pushpop_head", 64'(cdb_tag), 64'(11));
    for (int i = 0; i < 10; i++) step(1'b1, TW'(i), $urandom, 1'b1, 1'b0);
    repeat (4) step(1'b0, 4'd0, 32'h0, 1'b1, 1'b0);

    // Flush with simultaneous push and grant
    for (int i = 1; i <= 3; i++) step(1'b1, TW'(i), 32'(i), 1'b0, 1'b0);
    step(1'b1, 4'd6, 32'h6666, 1'b1, 1'b1);
    step(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_request", 64'(cdb_request), 64'(0));

    // Overflow on a full queue, sticky across flush
    for (int i = 1; i <= 4; i++) step(1'b1, TW'(i), 32'(i), 1'b0, 1'b0);
    step(1'b1, 4'd8, 32'h8888, 1'b0, 1'b0);
    step(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    chk("ovf_set", 64'(overflow_err), 64'(1));
    step(1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    chk("ovf_after_flush", 64'(overflow_err), 64'(1));

    // Asynchronous reset with two entries queued
    step(1'b1, 4'd1, 32'h1, 1'b0, 1'b0);
    step(1'b1, 4'd2, 32'h2, 1'b0, 1'b0);
    step(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_request", 64'(cdb_request), 64'(0));
    chk("async_rst_count", 64'(count), 64'(0));
    chk("async_rst_ready", 64'(fu_ready), 64'(1));
    chk("async_rst_ovf", 64'(overflow_err), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 4'd3, 32'h3333, 1'b0, 1'b0);
    step(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    chk("post_rst_tag", 64'(cdb_tag), 64'(3));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, TW'($urandom), $urandom, 1'($urandom), ($urandom % 40) == 0);
    end
    repeat (3) step(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
